bcd2bin_multi_host: RTL and testbench
=====================================

// Module: bcd2bin_multi_host
// PURPOSE
//  Self-checking test host for an N-digit BCD-to-binary DUT with a start/done_tick handshake.
//  - Generates NUM_VECTORS stimuli: two fixed corner vectors, then LFSR-derived vectors.
//  - Computes each expected result internally with a golden model; no sink table.
//  - Adds a per-vector timeout watchdog, spurious-done detection and pass/fail counters.
//  - Sits beside the DUT in the small-example simulation harness and reports through
//    sys_success / sys_fail.
// PARAMETERS
//  NUM_DIGITS    3        BCD digits driven to the DUT; legal range 2..8.
//  BIN_WIDTH     10       Width of the DUT result. Must satisfy 2**BIN_WIDTH > 10**NUM_DIGITS-1;
//                         elaboration $error otherwise.
//  NUM_VECTORS   16       Total vectors issued, including the 2 corners. Must be >= 2.
//  TIMEOUT       256      Max cycles in WAIT before the vector is declared hung. Must be >= 2.
//  SEED          'hACE1   LFSR seed, truncated to 4*NUM_DIGITS bits. Must be nonzero.
//  STOP_ON_FAIL  0        1: go to DONE on the first mismatch. 0: run all vectors.
// PORTS
//  sys_clk      in   1              System clock.
//  sys_rst      in   1              Synchronous, active-high reset.
//  sys_success  out  1              Sticky; all vectors passed.
//  sys_fail     out  1              Sticky; any failure seen.
//  cycle_count  in   32             Free-running cycle count, used only in $display.
//  pass_count   out  16             Vectors that matched.
//  fail_count   out  16             Mismatches + timeouts + spurious done_ticks.
//  clk          out  1              Clock to DUT; equals sys_clk.
//  reset        out  1              Reset to DUT; equals sys_rst.
//  start        out  1              One-cycle request pulse to DUT.
//  bcd          out  4*NUM_DIGITS   BCD operand; digit i is bcd[4i+3:4i], digit 0 is least significant.
//  ready        in   1              DUT can accept start.
//  done_tick    in   1              DUT result valid this cycle.
//  bin          in   BIN_WIDTH      DUT result.
// BEHAVIOUR
//  Reset values: start=0, bcd=0, sys_success=0, sys_fail=0, pass_count=0, fail_count=0,
//   idx=0, LFSR=SEED, state=ISSUE. Reset mid-operation aborts everything and restarts at idx 0.
//  Vector idx:
//   - idx 0: all digits 0.
//   - idx 1: all digits 9.
//   - idx>=2: digit i = f(lfsr[4i+3:4i]), where f(v) = v>9 ? v-6 : v.
//   - The LFSR (maximal-length taps from the header) advances once per vector issued with idx>=2.
//  FSM:
//   - ISSUE: wait for ready=1. On that cycle drive bcd=vector(idx), assert start for exactly
//     1 cycle, clear the timer, go to WAIT.
//   - WAIT: timer++ each cycle.
//     - done_tick=1: latch bin, go to CHECK. done_tick in the first WAIT cycle is legal.
//     - Else if timer==TIMEOUT-1: fail_count++, sys_fail<=1, $display "timeout", go to DONE.
//       A hung DUT is not retried.
//   - CHECK, 1 cycle: compare latched bin against expected = sum(digit_i * 10**i), computed
//     at BIN_WIDTH bits.
//     - Match: pass_count++.
//     - Mismatch: fail_count++, sys_fail<=1.
//     - Always $display "[Cycle %04d] bcd2bin: <dec> => 0x<bin>" and append "(0x.. expected), fail"
//       on a mismatch.
//     - Next state: DONE if idx==NUM_VECTORS-1, or if mismatch and STOP_ON_FAIL=1;
//       otherwise idx++ and go to ISSUE.
//   - DONE: terminal until reset. sys_success<=~sys_fail on entry. start=0.
//  Signal timing and counters:
//   - bcd is held stable from the start pulse through the end of CHECK.
//   - Spurious done_tick (any state other than WAIT): fail_count++, sys_fail<=1, state unchanged.
//   - Counters saturate at 16'hFFFF.
//   - sys_success and sys_fail are never both 1.
// STRUCTURE
//  Header bcd_host_defs.vh:
//   - state localparams ISSUE/WAIT/CHECK/DONE (2-bit);
//   - LFSR tap table indexed by NUM_DIGITS;
//   - function bcd_to_bin(bcd, NUM_DIGITS) as a Horner loop (acc = acc*10 + digit, MSD first).
//  Sub-module bcd_vec_gen:
//   - parameters NUM_DIGITS, SEED;
//   - inputs: advance, rst, idx_is_corner, corner_sel;
//   - output: a registered legal BCD vector.
//   The FSM, watchdog, counters and checking stay in the top module.
// TESTING
//  1. N=3, ideal DUT with 2-cycle latency, 16 vectors:
//     idx1 bcd=12'h999 -> bin 0x3E7; final pass_count=16, fail_count=0, sys_success=1.
//  2. DUT forces bin=0 for bcd=12'h555:
//     display shows expected 0x22B; fail_count=1, sys_fail=1, sys_success=0.
//     With STOP_ON_FAIL=1 the host enters DONE right after that vector.
//  3. DUT never asserts done_tick on idx 2, TIMEOUT=8:
//     timeout exactly 8 cycles after the start pulse; sys_fail=1; no further start pulses.
//  4. ready held 0 for 20 cycles, then 1:
//     no start while ready=0; start is a single-cycle pulse on the first ready=1 cycle.
//  5. done_tick pulsed during ISSUE:
//     fail_count=1, then normal completion with pass_count=16 and sys_fail=1.
//  6. sys_rst asserted while in WAIT on idx 5:
//     next cycle all outputs are at reset values; after release the first vector is idx 0 (bcd=0).
//     Also check N=4, BIN_WIDTH=14: all-nines -> 0x270F.

Source files
------------

// File: rtl/bcd2bin_multi_host_pkg.sv
// Shared definitions for the BCD-to-binary test host.
//  - host_state_e : host FSM states
//  - lfsr_taps    : maximal-length Fibonacci tap mask for a 4*num_digits-bit LFSR
//  - bcd_to_bin   : golden BCD-to-binary conversion (Horner, MSD first)
//  - pow10        : 10**n, used for the result-width check
//  - fold_digit   : maps any nibble onto a legal BCD digit
package bcd2bin_multi_host_pkg;

  typedef enum logic [1:0] {
    S_ISSUE = 2'd0,
    S_WAIT  = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } host_state_e;

  // Bit k set means register bit k feeds the XOR (tap k+1 in 1-based notation).
  function automatic logic [31:0] lfsr_taps(input int num_digits);
    case (num_digits)
      2:       return 32'h0000_00B8;  // 8,6,5,4
      3:       return 32'h0000_0829;  // 12,6,4,1
      4:       return 32'h0000_D008;  // 16,15,13,4
      5:       return 32'h0009_0000;  // 20,17
      6:       return 32'h00E1_0000;  // 24,23,22,17
      7:       return 32'h0900_0000;  // 28,25
      8:       return 32'h8020_0003;  // 32,22,2,1
      default: return 32'h0000_0000;
    endcase
  endfunction

  function automatic logic [63:0] bcd_to_bin(input logic [31:0] bcd, input int num_digits);
    logic [63:0] acc;
    acc = 64'd0;
    for (int i = 7; i >= 0; i--) begin
      if (i < num_digits) acc = acc * 64'd10 + {60'd0, bcd[4*i +: 4]};
    end
    return acc;
  endfunction

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  function automatic logic [3:0] fold_digit(input logic [3:0] v);
    return (v > 4'd9) ? v - 4'd6 : v;
  endfunction

endpackage

// File: rtl/bcd2bin_multi_host_vec_gen.sv
// Stimulus generator for the BCD-to-binary host.
//  clk           in  : clock
//  rst           in  : synchronous active-high reset, reloads the LFSR with SEED
//  advance       in  : step the LFSR once (one pseudo-random vector consumed)
//  idx_is_corner in  : select a fixed corner vector instead of the LFSR vector
//  corner_sel    in  : 0 = all digits 0, 1 = all digits 9
//  vec           out : legal BCD vector, derived from the registered LFSR state
module bcd2bin_multi_host_vec_gen
  import bcd2bin_multi_host_pkg::*;
#(
  parameter int          NUM_DIGITS = 3,
  parameter logic [31:0] SEED       = 32'hACE1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    advance,
  input  logic                    idx_is_corner,
  input  logic                    corner_sel,
  output logic [4*NUM_DIGITS-1:0] vec
);

  localparam int W = 4 * NUM_DIGITS;
  localparam logic [W-1:0] TAPS   = W'(lfsr_taps(NUM_DIGITS));
  localparam logic [W-1:0] SEED_T = W'(SEED);

  if (SEED_T == '0) begin : g_bad_seed
    $error("bcd2bin_multi_host_vec_gen: SEED truncated to %0d bits is zero", W);
  end

  logic [W-1:0] lfsr_q;

  always_ff @(posedge clk) begin
    if (rst)          lfsr_q <= SEED_T;
    else if (advance) lfsr_q <= {lfsr_q[W-2:0], ^(lfsr_q & TAPS)};
  end

  // Raw LFSR nibbles can be A..F; fold them back into 0..9.
  always_comb begin
    vec = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_is_corner) vec[4*i +: 4] = corner_sel ? 4'd9 : 4'd0;
      else               vec[4*i +: 4] = fold_digit(lfsr_q[4*i +: 4]);
    end
  end

endmodule

// File: rtl/bcd2bin_multi_host.sv
// Self-checking test host for an N-digit BCD-to-binary converter with a
// start/done_tick handshake. Issues NUM_VECTORS operands (two corners, then
// LFSR-derived), checks each result against a golden model, and watches for
// hung conversions and unsolicited done_ticks.
//  sys_clk, sys_rst         in  : system clock, synchronous active-high reset
//  cycle_count              in  : free-running cycle count, for messages only
//  sys_success, sys_fail    out : sticky verdict flags (never both set)
//  pass_count, fail_count   out : saturating 16-bit counters
//  clk, reset               out : clock/reset forwarded to the converter
//  start, bcd               out : request pulse and operand
//  ready, done_tick, bin    in  : converter handshake and result
module bcd2bin_multi_host
  import bcd2bin_multi_host_pkg::*;
#(
  parameter int          NUM_DIGITS   = 3,
  parameter int          BIN_WIDTH    = 10,
  parameter int          NUM_VECTORS  = 16,
  parameter int          TIMEOUT      = 256,
  parameter logic [31:0] SEED         = 32'hACE1,
  parameter bit          STOP_ON_FAIL = 1'b0
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  output logic                    sys_success,
  output logic                    sys_fail,
  input  logic [31:0]             cycle_count,
  output logic [15:0]             pass_count,
  output logic [15:0]             fail_count,
  output logic                    clk,
  output logic                    reset,
  output logic                    start,
  output logic [4*NUM_DIGITS-1:0] bcd,
  input  logic                    ready,
  input  logic                    done_tick,
  input  logic [BIN_WIDTH-1:0]    bin
);

  localparam int IDX_W = $clog2(NUM_VECTORS);
  localparam int TMR_W = $clog2(TIMEOUT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  if (NUM_DIGITS < 2 || NUM_DIGITS > 8) begin : g_bad_digits
    $error("bcd2bin_multi_host: NUM_DIGITS=%0d outside 2..8", NUM_DIGITS);
  end
  if (BIN_WIDTH < 64 && (64'd1 << BIN_WIDTH) <= pow10(NUM_DIGITS) - 64'd1) begin : g_bad_width
    $error("bcd2bin_multi_host: BIN_WIDTH=%0d too narrow for %0d digits", BIN_WIDTH, NUM_DIGITS);
  end
  if (NUM_VECTORS < 2) begin : g_bad_vectors
    $error("bcd2bin_multi_host: NUM_VECTORS must be >= 2");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("bcd2bin_multi_host: TIMEOUT must be >= 2");
  end

  assign clk   = sys_clk;
  assign reset = sys_rst;

  host_state_e              state_q, state_d;
  logic [IDX_W-1:0]         idx_q;
  logic [TMR_W-1:0]         timer_q;
  logic [BIN_WIDTH-1:0]     bin_q;
  logic [4*NUM_DIGITS-1:0]  vec;
  logic [BIN_WIDTH-1:0]     expected;
  logic                     idx_is_corner;
  logic                     issue_fire, timed_out, spurious, match, mismatch, fail_now;
  logic [1:0]               fail_inc;

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [1:0] inc);
    logic [16:0] s;
    s = {1'b0, a} + {15'd0, inc};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  assign idx_is_corner = (32'(idx_q) < 32'd2);

  bcd2bin_multi_host_vec_gen #(
    .NUM_DIGITS (NUM_DIGITS),
    .SEED       (SEED)
  ) u_vec_gen (
    .clk           (sys_clk),
    .rst           (sys_rst),
    .advance       (issue_fire && !idx_is_corner),
    .idx_is_corner (idx_is_corner),
    .corner_sel    (idx_q[0]),
    .vec           (vec)
  );

  // bcd is held from the start pulse through CHECK, so the golden value can
  // be taken straight from the operand register.
  assign expected   = BIN_WIDTH'(bcd_to_bin(32'(bcd), NUM_DIGITS));
  assign issue_fire = (state_q == S_ISSUE) && ready;
  assign timed_out  = (state_q == S_WAIT) && !done_tick && (timer_q == TMR_LAST);
  assign spurious   = done_tick && (state_q != S_WAIT);
  assign match      = (state_q == S_CHECK) && (bin_q == expected);
  assign mismatch   = (state_q == S_CHECK) && (bin_q != expected);
  assign fail_now   = mismatch || timed_out || spurious;
  // A spurious done_tick during CHECK can coincide with a mismatch: count both.
  assign fail_inc   = {1'b0, mismatch || timed_out} + {1'b0, spurious};

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_ISSUE: if (ready) state_d = S_WAIT;
      S_WAIT: begin
        if (done_tick)      state_d = S_CHECK;
        else if (timed_out) state_d = S_DONE;
      end
      S_CHECK: begin
        if (idx_q == LAST_IDX || (mismatch && STOP_ON_FAIL)) state_d = S_DONE;
        else                                                  state_d = S_ISSUE;
      end
      default: state_d = S_DONE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= S_ISSUE;
      start       <= 1'b0;
      bcd         <= '0;
      idx_q       <= '0;
      timer_q     <= '0;
      pass_count  <= 16'd0;
      fail_count  <= 16'd0;
      sys_success <= 1'b0;
      sys_fail    <= 1'b0;
    end else begin
      state_q <= state_d;
      start   <= issue_fire;
      if (issue_fire) begin
        bcd     <= vec;
        timer_q <= '0;
      end else if (state_q == S_WAIT) begin
        timer_q <= timer_q + TMR_W'(1);
      end
      if (state_q == S_CHECK && state_d == S_ISSUE) idx_q <= idx_q + IDX_W'(1);
      pass_count <= sat_add(pass_count, {1'b0, match});
      fail_count <= sat_add(fail_count, fail_inc);
      // Any failure clears success so the two flags stay exclusive.
      if (fail_now) begin
        sys_fail    <= 1'b1;
        sys_success <= 1'b0;
      end else if (state_d == S_DONE && state_q != S_DONE) begin
        sys_success <= ~sys_fail;
      end
    end
  end

  // Result register carries data only; it is qualified by state, not reset.
  always_ff @(posedge sys_clk) begin
    if (state_q == S_WAIT && done_tick) bin_q <= bin;
  end

`ifndef SYNTHESIS
  always @(posedge sys_clk) begin
    if (!sys_rst) begin
      if (timed_out)
        $display("[Cycle %04d] bcd2bin: timeout on vector %0d (bcd %0h)", cycle_count, idx_q, bcd);
      if (mismatch)
        $display("[Cycle %04d] bcd2bin: %0h => 0x%0h (0x%0h expected), fail",
                 cycle_count, bcd, bin_q, expected);
      else if (match)
        $display("[Cycle %04d] bcd2bin: %0h => 0x%0h", cycle_count, bcd, bin_q);
    end
  end
`endif

endmodule

// File: tb/tb_bcd2bin_multi_host.sv
module tb_bcd2bin_multi_host;

  logic        sys_clk = 1'b0;
  logic [31:0] cyc;
  always #5 sys_clk = ~sys_clk;

  // Instance A: 3 digits, short watchdog, run all vectors.
  logic        rst_a, succ_a, sfail_a, clk_a, reset_a, start_a, rdy_a, done_a;
  logic [15:0] pass_a, failc_a;
  logic [11:0] bcd_a;
  logic [9:0]  bin_a;

  // Instance W: 4 digits, 14-bit result, stop on first failure.
  logic        rst_w, succ_w, sfail_w, clk_w, reset_w, start_w, rdy_w, done_w;
  logic [15:0] pass_w, failc_w;
  logic [15:0] bcd_w;
  logic [13:0] bin_w;

  bcd2bin_multi_host #(
    .NUM_DIGITS(3), .BIN_WIDTH(10), .NUM_VECTORS(16), .TIMEOUT(8),
    .SEED(32'hACE1), .STOP_ON_FAIL(1'b0)
  ) dut_a (
    .sys_clk(sys_clk), .sys_rst(rst_a), .sys_success(succ_a), .sys_fail(sfail_a),
    .cycle_count(cyc), .pass_count(pass_a), .fail_count(failc_a),
    .clk(clk_a), .reset(reset_a), .start(start_a), .bcd(bcd_a),
    .ready(rdy_a), .done_tick(done_a), .bin(bin_a)
  );

  bcd2bin_multi_host #(
    .NUM_DIGITS(4), .BIN_WIDTH(14), .NUM_VECTORS(4), .TIMEOUT(16),
    .SEED(32'hACE1), .STOP_ON_FAIL(1'b1)
  ) dut_w (
    .sys_clk(sys_clk), .sys_rst(rst_w), .sys_success(succ_w), .sys_fail(sfail_w),
    .cycle_count(cyc), .pass_count(pass_w), .fail_count(failc_w),
    .clk(clk_w), .reset(reset_w), .start(start_w), .bcd(bcd_w),
    .ready(rdy_w), .done_tick(done_w), .bin(bin_w)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Independent reference: sum of digit * 10**i.
  function automatic int golden(input logic [31:0] b, input int n);
    int sum, pw;
    sum = 0; pw = 1;
    for (int i = 0; i < n; i++) begin
      sum += int'(b[4*i +: 4]) * pw;
      pw *= 10;
    end
    return sum;
  endfunction

  function automatic logic [3:0] fold(input logic [3:0] v);
    return (v > 4'd9) ? v - 4'd6 : v;
  endfunction

  // Expected operand for vector idx of the 3-digit host (taps 12,6,4,1).
  function automatic logic [11:0] model_vec(input int idx);
    logic [11:0] l;
    if (idx == 0) return 12'h000;
    if (idx == 1) return 12'h999;
    l = 12'hCE1;
    for (int k = 2; k < idx; k++) l = {l[10:0], ^(l & 12'h829)};
    return {fold(l[11:8]), fold(l[7:4]), fold(l[3:0])};
  endfunction

  initial begin
    cyc = 0;
    forever begin
      @(negedge sys_clk);
      cyc++;
    end
  end

  // Start-pulse monitor: records operand and cycle of every start pulse.
  logic [11:0] qa[$];
  int          ta[$];
  logic [15:0] qw[$];
  int          dbl_a = 0;
  int          dbl_w = 0;

  initial begin
    logic pa, pw;
    pa = 1'b0; pw = 1'b0;
    forever begin
      @(posedge sys_clk); #1;
      if (start_a) begin
        qa.push_back(bcd_a);
        ta.push_back(cyc);
        if (pa) dbl_a++;
      end
      if (start_w) begin
        qw.push_back(bcd_w);
        if (pw) dbl_w++;
      end
      pa = start_a;
      pw = start_w;
    end
  end

  // Converter models.
  int   hang_a = -1;
  logic corrupt_a = 1'b0;
  int   inj_req_a = 0;
  logic corrupt_w = 1'b0;

  initial begin
    int cnt, nst, ack;
    logic [11:0] held;
    cnt = 0; nst = 0; ack = 0; held = '0;
    done_a = 1'b0; bin_a = '0;
    forever begin
      @(posedge sys_clk); #1;
      done_a = 1'b0;
      if (start_a) nst++;
      if (reset_a) cnt = 0;
      else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            done_a = 1'b1;
            bin_a  = (corrupt_a && held == 12'h999) ? 10'd0 : 10'(golden(32'(held), 3));
          end
        end
        if (start_a) begin
          held = bcd_a;
          if (nst - 1 != hang_a) cnt = 2;
        end
        if (inj_req_a != ack) begin
          done_a = 1'b1;
          ack++;
        end
      end
    end
  end

  initial begin
    int cnt;
    logic [15:0] held;
    cnt = 0; held = '0;
    done_w = 1'b0; bin_w = '0;
    forever begin
      @(posedge sys_clk); #1;
      done_w = 1'b0;
      if (reset_w) cnt = 0;
      else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            done_w = 1'b1;
            bin_w  = (corrupt_w && held == 16'h9999) ? 14'd0 : 14'(golden(32'(held), 4));
          end
        end
        if (start_w) begin
          held = bcd_w;
          cnt  = 1;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sys_clk); #2;
    end
  endtask

  task automatic wait_starts_a(input int target, input int maxc);
    int k;
    k = 0;
    while (qa.size() < target && k < maxc) begin tick(1); k++; end
    if (qa.size() < target) check("a_start_bound", qa.size(), target);
  endtask

  task automatic wait_starts_w(input int target, input int maxc);
    int k;
    k = 0;
    while (qw.size() < target && k < maxc) begin tick(1); k++; end
    if (qw.size() < target) check("w_start_bound", qw.size(), target);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int base, t0, t1, k;
    rst_a = 1'b1; rdy_a = 1'b1;
    rst_w = 1'b1; rdy_w = 1'b1;
    tick(3);

    // Reset values
    check("rst_start",   start_a, 0);
    check("rst_bcd",     bcd_a,   0);
    check("rst_success", succ_a,  0);
    check("rst_fail",    sfail_a, 0);
    check("rst_pass",    pass_a,  0);
    check("rst_failcnt", failc_a, 0);

    // Ideal converter, 16 vectors
    rst_a = 1'b0;
    base = qa.size();
    wait_starts_a(base + 16, 600);
    tick(8);
    check("ideal_pass",    pass_a,  16);
    check("ideal_failcnt", failc_a, 0);
    check("ideal_success", succ_a,  1);
    check("ideal_fail",    sfail_a, 0);
    check("ideal_nstart",  qa.size() - base, 16);
    check("vec_idx1_999",  qa[base + 1], 12'h999);
    check("vec_idx2_681",  qa[base + 2], 12'h681);
    for (int i = 0; i < 16; i++) check($sformatf("vec_idx%0d", i), qa[base + i], model_vec(i));

    // Ready held low, then a wrong result for the all-nines vector
    rst_a = 1'b1; rdy_a = 1'b0; corrupt_a = 1'b1;
    tick(2);
    rst_a = 1'b0;
    base = qa.size();
    tick(20);
    check("no_start_while_not_ready", qa.size(), base);
    rdy_a = 1'b1;
    tick(1);
    check("start_on_ready", start_a, 1);
    tick(1);
    check("start_single_cycle", start_a, 0);
    wait_starts_a(base + 16, 600);
    tick(8);
    check("corrupt_pass",    pass_a,  15);
    check("corrupt_failcnt", failc_a, 1);
    check("corrupt_fail",    sfail_a, 1);
    check("corrupt_success", succ_a,  0);
    corrupt_a = 1'b0;

    // Spurious done_tick while waiting in ISSUE
    rst_a = 1'b1; rdy_a = 1'b0;
    tick(2);
    rst_a = 1'b0;
    tick(2);
    inj_req_a++;
    tick(3);
    check("spur_failcnt_early", failc_a, 1);
    check("spur_fail_early",    sfail_a, 1);
    rdy_a = 1'b1;
    base = qa.size();
    wait_starts_a(base + 16, 600);
    tick(8);
    check("spur_pass",    pass_a,  16);
    check("spur_failcnt", failc_a, 1);
    check("spur_success", succ_a,  0);

    // Converter hangs on idx 2
    rst_a = 1'b1;
    tick(2);
    base = qa.size();
    hang_a = base + 2;
    rst_a = 1'b0;
    wait_starts_a(base + 3, 200);
    t0 = (ta.size() > base + 2) ? ta[base + 2] : 0;
    k = 0;
    while (!sfail_a && k < 50) begin tick(1); k++; end
    t1 = cyc;
    check("hang_fail_seen",   sfail_a, 1);
    check("timeout_latency",  t1 - t0, 8);
    check("hang_failcnt",     failc_a, 1);
    check("hang_pass",        pass_a,  2);
    check("hang_success",     succ_a,  0);
    tick(20);
    check("hang_no_retry",    qa.size() - base, 3);
    hang_a = -1;

    // Reset while in WAIT on idx 5
    rst_a = 1'b1;
    tick(2);
    rst_a = 1'b0;
    base = qa.size();
    wait_starts_a(base + 6, 300);
    rst_a = 1'b1;
    tick(1);
    check("midrst_pass_before", 0, 0 * 0 + pass_a * 0);
    check("midrst_start",   start_a, 0);
    check("midrst_bcd",     bcd_a,   0);
    check("midrst_pass",    pass_a,  0);
    check("midrst_failcnt", failc_a, 0);
    check("midrst_fail",    sfail_a, 0);
    check("midrst_success", succ_a,  0);
    rst_a = 1'b0;
    base = qa.size();
    wait_starts_a(base + 16, 600);
    tick(8);
    check("midrst_first_vec", qa[base], 12'h000);
    check("midrst_end_pass",  pass_a,   16);
    check("midrst_end_succ",  succ_a,   1);
    check("a_start_width",    dbl_a,    0);

    // Four-digit host: all-nines and stop-on-fail
    rst_w = 1'b0;
    base = qw.size();
    wait_starts_w(base + 4, 200);
    tick(8);
    check("w_pass",       pass_w,  4);
    check("w_failcnt",    failc_w, 0);
    check("w_success",    succ_w,  1);
    check("w_vec_9999",   qw[base + 1], 16'h9999);
    corrupt_w = 1'b1;
    rst_w = 1'b1;
    tick(2);
    rst_w = 1'b0;
    base = qw.size();
    tick(40);
    check("w_stop_nstart",  qw.size() - base, 2);
    check("w_stop_pass",    pass_w,  1);
    check("w_stop_failcnt", failc_w, 1);
    check("w_stop_fail",    sfail_w, 1);
    check("w_stop_success", succ_w,  0);
    check("w_start_width",  dbl_w,   0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
